// File: rtl/clock_divider_multi.sv
// ---------------------------------------------------------------------------
// clock_divider_multi
//   Multi-channel programmable clock/strobe generator. Each channel divides the
//   system clock by a run-time programmable period with a programmable high
//   time. New settings are held as "pending" and take over only at a period
//   boundary, so the divided clock never glitches.
//
// Ports
//   clock     in   system clock, all logic on the rising edge
//   reset     in   synchronous, active-high reset
//   enable    in   [NUM_CH]        per-channel run enable
//   load      in   single-cycle pulse, samples period_i/high_i for all channels
//   period_i  in   [NUM_CH*CNT_W]  channel c period at [c*CNT_W +: CNT_W]
//   high_i    in   [NUM_CH*CNT_W]  channel c high time, same packing
//   clk_out   out  [NUM_CH]        divided clocks, registered
//   tick      out  [NUM_CH]        one-cycle pulse on the first cycle of a period
//   pending   out  [NUM_CH]        loaded values waiting for the next boundary
//   err       out  [NUM_CH]        sticky: a load with period 0 was rejected
// ---------------------------------------------------------------------------
module clock_divider_multi #(
   parameter int NUM_CH     = 1,
   parameter int CNT_W      = 8,
   parameter int PERIOD_RST = 4,
   parameter int HIGH_RST   = 1
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic [NUM_CH-1:0]       enable,
   input  logic                    load,
   input  logic [NUM_CH*CNT_W-1:0] period_i,
   input  logic [NUM_CH*CNT_W-1:0] high_i,
   output logic [NUM_CH-1:0]       clk_out,
   output logic [NUM_CH-1:0]       tick,
   output logic [NUM_CH-1:0]       pending,
   output logic [NUM_CH-1:0]       err
);

   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      logic [CNT_W-1:0] per_in, high_in;
      logic [CNT_W-1:0] cnt, per_act, high_act, per_pend, high_pend;
      logic [CNT_W-1:0] nxt, cnt_d, per_d, high_d;
      logic             load_ok, load_bad, apply;
      logic             clk_q, tick_q, pend_q, err_q;

      assign per_in  = period_i[c*CNT_W +: CNT_W];
      assign high_in = high_i[c*CNT_W +: CNT_W];

      // NOTE: every signal written here gets a value before any branch, so no
      // path leaves one unassigned and no latch is inferred.
      always_comb begin
         load_ok  = load && (per_in != '0);
         load_bad = load && (per_in == '0);
         nxt      = (cnt == per_act - CNT_W'(1)) ? '0 : cnt + CNT_W'(1);
         apply    = pend_q && (nxt == '0);
         per_d    = per_act;
         high_d   = high_act;
         cnt_d    = nxt;
         if (enable[c]) begin
            // The cycle entered at the boundary already uses the new high time.
            if (apply) begin
               per_d  = per_pend;
               high_d = high_pend;
            end
         end else begin
            // A stopped channel has no boundary to wait for: apply at once.
            if (load_ok) begin
               per_d  = per_in;
               high_d = high_in;
            end
            // Park one count before the wrap of the (possibly new) period so
            // re-enabling starts a fresh period on the very next edge.
            cnt_d = per_d - CNT_W'(1);
         end
      end

      // NOTE: state registers use non-blocking assignments so every register
      // samples pre-edge values; the combinational block above uses blocking.
      always_ff @(posedge clock) begin
         if (reset) begin
            cnt      <= '0;
            per_act  <= CNT_W'(PERIOD_RST);
            high_act <= CNT_W'(HIGH_RST);
            clk_q    <= 1'b0;
            tick_q   <= 1'b0;
            pend_q   <= 1'b0;
            err_q    <= 1'b0;
         end else begin
            cnt      <= cnt_d;
            per_act  <= per_d;
            high_act <= high_d;
            clk_q    <= enable[c] && (nxt < high_d);
            tick_q   <= enable[c] && (nxt == '0);
            err_q    <= err_q | load_bad;
            if (load_ok)
               pend_q <= enable[c];
            else if (enable[c] && apply)
               pend_q <= 1'b0;
         end
      end

      // NOTE: the pending value holders are deliberately not reset; they are
      // only ever read while pend_q is set, and reset clears pend_q.
      always_ff @(posedge clock) begin
         if (load_ok) begin
            per_pend  <= per_in;
            high_pend <= high_in;
         end
      end

      assign clk_out[c] = clk_q;
      assign tick[c]    = tick_q;
      assign pending[c] = pend_q;
      assign err[c]     = err_q;
   end

endmodule
